mem_bus_arbiter: RTL

//  N-master byte-wide memory bus arbiter and region decoder. Generalises the top-level CPU/HCI mux:
//  any number of masters (I-fetch, D-access, HCI debug), round-robin fairness, debug exclusive hold.

---
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin N-master byte bus arbiter with RAM / HCI-IO region decode and 1-cycle read return.
// Define MEMBUS_PERF_EN to add the perf_conflict_cnt contention counter output.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             dbg_hold,
  input  logic [NUM_MASTERS-1:0]           m_req,
  input  logic [NUM_MASTERS-1:0]           m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
  input  logic [NUM_MASTERS*8-1:0]         m_dout,
  output logic [NUM_MASTERS-1:0]           m_grant,
  output logic [7:0]                       m_din,
  output logic [NUM_MASTERS-1:0]           m_din_valid,
  output logic                             ram_en,
  output logic                             ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0]        ram_a,
  output logic [7:0]                       ram_d,
  input  logic [7:0]                       ram_q,
  output logic                             io_en,
  output logic                             io_wr,
  output logic [2:0]                       io_sel,
  output logic [7:0]                       io_d,
  input  logic [7:0]                       io_q,
  input  logic                             io_full
`ifdef MEMBUS_PERF_EN
  ,
  output logic [31:0]                      perf_conflict_cnt
`endif
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PW-1:0]            ptr_q, ptr_d;
  logic [PW-1:0]            q_owner_q, q_owner_d;
  logic                     q_io_q, q_io_d;
  logic                     q_vld_q, q_vld_d;
  logic [NUM_MASTERS-1:0]   io_region, eligible;
  logic [2*NUM_MASTERS-1:0] rot;
  logic [PW:0]              sum;
  logic                     gnt_any;
  logic [PW-1:0]            gnt_idx;
  logic [ADDR_WIDTH-1:0]    sel_a;
  logic [7:0]               sel_dout;
  logic                     sel_wr, sel_io;
  logic                     unused_sig;

  // A full IO TX buffer blocks only IO writes; debug hold masks every master but the last.
  always_comb begin
    io_region = '0;
    eligible  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      io_region[i] = (m_a[i*ADDR_WIDTH + RAM_ADDR_WIDTH -: 2] == 2'b11);
      eligible[i]  = m_req[i] & rdy_in & ~(io_region[i] & m_wr[i] & io_full)
                     & (~dbg_hold | (i == NUM_MASTERS-1));
    end
  end

  // Rotate so bit k is master (ptr+k) mod N; scanning high to low leaves the nearest one.
  always_comb begin
    rot     = {eligible, eligible} >> ptr_q;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_q} + (PW+1)'(k);
        if (sum >= (PW+1)'(NUM_MASTERS)) sum = sum - (PW+1)'(NUM_MASTERS);
        gnt_any = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_dout = '0;
    sel_wr   = 1'b0;
    sel_io   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_a    = m_a[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dout = m_dout[i*8 +: 8];
        sel_wr   = m_wr[i];
        sel_io   = io_region[i];
      end
    end
  end

  always_comb begin
    m_grant  = '0;
    ram_en   = 1'b0;
    ram_r_nw = 1'b1;
    ram_a    = '0;
    ram_d    = '0;
    io_en    = 1'b0;
    io_wr    = 1'b0;
    io_sel   = '0;
    io_d     = '0;
    if (gnt_any) begin
      m_grant[gnt_idx] = 1'b1;
      if (sel_io) begin
        io_en  = 1'b1;
        io_wr  = sel_wr;
        io_sel = sel_a[2:0];
        io_d   = sel_dout;
      end else begin
        ram_en   = 1'b1;
        ram_r_nw = ~sel_wr;
        ram_a    = sel_a[RAM_ADDR_WIDTH-1:0];
        ram_d    = sel_dout;
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    q_owner_d = q_owner_q;
    q_io_d    = q_io_q;
    q_vld_d   = 1'b0;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PW'(NUM_MASTERS-1)) ? '0 : gnt_idx + PW'(1);
      if (!sel_wr) begin
        q_vld_d   = 1'b1;
        q_owner_d = gnt_idx;
        q_io_d    = sel_io;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_q     <= '0;
      q_owner_q <= '0;
      q_io_q    <= 1'b0;
      q_vld_q   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      q_owner_q <= q_owner_d;
      q_io_q    <= q_io_d;
      q_vld_q   <= q_vld_d;
    end
  end

  // Read data returns from whichever slave was addressed by last cycle's read grant.
  assign m_din = q_io_q ? io_q : ram_q;

  always_comb begin
    m_din_valid = '0;
    if (q_vld_q) m_din_valid[q_owner_q] = 1'b1;
  end

  assign unused_sig = ^{sel_a, rot, sum};

`ifdef MEMBUS_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        multi_elig;

  assign multi_elig = (eligible & (eligible - NUM_MASTERS'(1))) != '0;

  always_comb begin
    perf_d = perf_q;
    if (multi_elig && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_conflict_cnt = perf_q;
`endif

endmodule
